mem_dump_unit: RTL and testbench
================================

# mem_dump_unit

Sequential read-back engine for the byte-addressed data RAM of the pipelined RISC-V core. The RAM contents are written by the program loader and by store instructions. On a start pulse, this block reads a word-aligned range of the RAM one byte per cycle, assembles little-endian 32-bit words, and streams them out with their addresses over a valid/ready handshake. It sits beside the MEM stage on the RAM's debug byte-read port and provides a synthesizable equivalent of the bench's end-of-run word dump.

## Interface
Parameters:
- ADDR_W, 9, byte-address width of the data RAM (512 bytes)
- CNT_W, 8, width of the word-count field

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high; sampled on the clk rising edge
- start  in  1  request a dump; honored only in IDLE
- base_addr  in  ADDR_W  first byte address; bits [1:0] are forced to 0 at capture
- word_count  in  CNT_W  number of words to dump; captured with start
- mem_en  out  1  byte-read enable to the RAM debug port
- mem_addr  out  ADDR_W  byte address being read
- mem_data  in  8  RAM byte at mem_addr; combinational, valid in the same cycle
- dump_valid  out  1  dump_word/dump_addr hold a complete word
- dump_ready  in  1  consumer accepts the word
- dump_word  out  32  assembled word, {Mem[a+3],Mem[a+2],Mem[a+1],Mem[a]}
- dump_addr  out  ADDR_W  address a of byte 0 of dump_word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the dump completes

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE + start=1 with word_count≠0: capture base (low 2 bits cleared) into cur_addr and word_count into remaining, clear byte index, then go to READ.
- IDLE + start=1 with word_count=0: go to DONE with no RAM access and no dump_valid.
- READ: mem_en=1, mem_addr=cur_addr+idx, with idx counting 0..3. On each edge, mem_data is written into byte lane idx of the word register.
  - When idx=3: clear idx, latch dump_addr=cur_addr, go to SEND.
- SEND: dump_valid=1. dump_word and dump_addr stay stable until the handshake.
  - On an edge with dump_ready=1: decrement remaining and advance cur_addr by 4.
  - If remaining was 1, go to DONE; otherwise go to READ.
- DONE: done=1 for exactly one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDR_W. A word starting at 508 is followed by a word at 0, and byte addresses 508..511 never wrap inside a word.
- start is ignored outside IDLE. base_addr and word_count are don't-care after capture.
- mem_en=0 and mem_addr=0 outside READ. The block never writes the RAM.

## Timing
- Reset values: busy=0, done=0, dump_valid=0, dump_word=0, dump_addr=0, mem_en=0, mem_addr=0, state IDLE.
  - Internal counters are also cleared: idx, remaining, cur_addr.
- Reset asserted mid-dump: the next edge forces IDLE and aborts the dump. No done pulse and no partial word is emitted.
- reset takes precedence over start in the same cycle.
- Latency, with start sampled at edge 0:
  - READ occupies cycles 1–4.
  - dump_valid first goes high in cycle 5.
  - With dump_ready held at 1, the handshake occurs at the end of cycle 5.
- Throughput: 5 cycles per word when ready is always high. Each cycle of dump_ready=0 adds one cycle.
- done is high in the cycle after the final handshake. busy falls in the cycle after done.
- dump_valid never drops without a handshake. dump_word is held after the handshake until the next SEND.

## Configuration
- MEM_DUMP_CHECKSUM_EN defined:
  - Adds output checksum (32 bits), reset to 0.
  - checksum is cleared when a start is accepted.
  - On every handshake, dump_word is added to checksum modulo 2^32.
  - The value is final and stable from the done cycle until the next accepted start.
- Macro undefined: the checksum port and adder do not exist. All other behaviour is identical.

## Test plan
- Single word: RAM[180..183]=0x11,0x22,0x33,0x44; start with base=180, count=1, ready=1.
  - mem_addr reads 180,181,182,183 in cycles 1–4.
  - Cycle 5: dump_valid=1, dump_word=0x44332211, dump_addr=180.
  - Cycle 6: done=1.
- Multi-word with backpressure: base=180, count=11, ready toggled 0/1 every cycle.
  - Exactly 11 words are emitted, at addresses 180, 184, …, 220.
  - Each dump_word matches the RAM model and stays stable while valid=1 and ready=0.
- Alignment and wrap: base=0x1FF (forced to 508), count=2.
  - Outputs are dump_addr=508 then dump_addr=0, with mem_addr sequence 508..511, 0..3.
- Zero count and ignored start:
  - count=0 gives done=1 one cycle after start, with dump_valid and mem_en never asserted.
  - A second start during READ changes nothing.
- Reset mid-dump: count=4; assert reset in cycle 7.
  - Next cycle: busy=0, dump_valid=0, mem_en=0, and done never pulses.
  - A fresh start afterwards dumps correctly from the new base.
- Checksum (MEM_DUMP_CHECKSUM_EN): words 0xFFFFFFFF and 0x00000002.
  - checksum=0x00000001 at done.

Source files
------------

// File: rtl/mem_dump_unit_if.sv
// Bundles the debug byte-read port of the data RAM and the outgoing word stream
// of mem_dump_unit. The master modport is the dump engine side.
interface mem_dump_unit_if #(
   parameter int ADDR_W = 9
);
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic              dump_valid;
   logic              dump_ready;
   logic [31:0]       dump_word;
   logic [ADDR_W-1:0] dump_addr;

   modport master (
      output mem_en, mem_addr, dump_valid, dump_word, dump_addr,
      input  mem_data, dump_ready
   );

   modport slave (
      input  mem_en, mem_addr, dump_valid, dump_word, dump_addr,
      output mem_data, dump_ready
   );
endinterface

// File: rtl/mem_dump_unit.sv
// Reads a word-aligned RAM range one byte per cycle and streams little-endian words.
// Optional running checksum of emitted words: define MEM_DUMP_CHECKSUM_EN.
module mem_dump_unit #(
   parameter int ADDR_W = 9,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   mem_dump_unit_if.master   bus,
   output logic              busy,
   output logic              done
`ifdef MEM_DUMP_CHECKSUM_EN
   ,
   output logic [31:0]       checksum
`endif
);

   typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

   state_t            state;
   logic [1:0]        idx;
   logic [CNT_W-1:0]  remaining;
   logic [ADDR_W-1:0] cur_addr;
   logic [23:0]       word_buf;
   logic [ADDR_W-1:0] aligned_base;
   logic [ADDR_W-1:0] next_byte_addr;
   logic [ADDR_W-1:0] next_word_addr;

   // mem_addr is registered, so it is always loaded one cycle ahead of the byte it fetches
   assign aligned_base   = base_addr & ~ADDR_W'(3);
   assign next_byte_addr = cur_addr + ADDR_W'(idx) + ADDR_W'(1);
   assign next_word_addr = cur_addr + ADDR_W'(4);

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         idx            <= '0;
         remaining      <= '0;
         cur_addr       <= '0;
         word_buf       <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         bus.mem_en     <= 1'b0;
         bus.mem_addr   <= '0;
         bus.dump_valid <= 1'b0;
         bus.dump_word  <= '0;
         bus.dump_addr  <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
         checksum       <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy      <= 1'b1;
                  cur_addr  <= aligned_base;
                  remaining <= word_count;
                  idx       <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
                  checksum  <= '0;
`endif
                  if (word_count != '0) begin
                     state        <= READ;
                     bus.mem_en   <= 1'b1;
                     bus.mem_addr <= aligned_base;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            READ: begin
               // The top byte bypasses word_buf so dump_word updates in one step
               if (idx == 2'd3) begin
                  idx            <= '0;
                  bus.dump_word  <= {bus.mem_data, word_buf};
                  bus.dump_addr  <= cur_addr;
                  bus.dump_valid <= 1'b1;
                  bus.mem_en     <= 1'b0;
                  bus.mem_addr   <= '0;
                  state          <= SEND;
               end else begin
                  case (idx)
                     2'd0:    word_buf[7:0]   <= bus.mem_data;
                     2'd1:    word_buf[15:8]  <= bus.mem_data;
                     default: word_buf[23:16] <= bus.mem_data;
                  endcase
                  idx          <= idx + 2'd1;
                  bus.mem_addr <= next_byte_addr;
               end
            end
            SEND: begin
               if (bus.dump_ready) begin
                  bus.dump_valid <= 1'b0;
                  remaining      <= remaining - CNT_W'(1);
                  cur_addr       <= next_word_addr;
`ifdef MEM_DUMP_CHECKSUM_EN
                  checksum       <= checksum + bus.dump_word;
`endif
                  if (remaining == CNT_W'(1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state        <= READ;
                     bus.mem_en   <= 1'b1;
                     bus.mem_addr <= next_word_addr;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_dump_unit.sv
// Randomized bench for mem_dump_unit against a RAM array and an expected-word/read-address model.
// Checksum checks are compiled in when MEM_DUMP_CHECKSUM_EN is defined.
module tb_mem_dump_unit;
   localparam int ADDR_W = 9;
   localparam int CNT_W  = 8;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       word;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  word_count;
   logic              busy;
   logic              done;
`ifdef MEM_DUMP_CHECKSUM_EN
   logic [31:0]       checksum;
`endif

   logic [7:0]        ram [0:(1<<ADDR_W)-1];
   exp_t              expWordQ [$];
   logic [ADDR_W-1:0] expReadQ [$];
   exp_t              frontWord;
   logic [31:0]       sumModel;
   int                cyc;
   int                firstValid;
   int                readyMode;
   int                checks = 0;
   int                errors = 0;
   bit                monitorOn = 1'b0;

   mem_dump_unit_if #(.ADDR_W(ADDR_W)) bus ();
   assign bus.mem_data = ram[bus.mem_addr];

   mem_dump_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .bus        (bus),
      .busy       (busy),
      .done       (done)
`ifdef MEM_DUMP_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Every RAM read and every presented word is matched against the model queues
   always @(negedge clk) begin
      if (monitorOn && !reset) begin
         if (bus.mem_en) begin
            checkOutput("busy_while_reading", {31'b0, busy}, 32'd1);
            if (expReadQ.size() == 0)
               checkOutput("unexpected_read", {31'b0, bus.mem_en}, 32'd0);
            else
               checkOutput("mem_addr", 32'(bus.mem_addr), 32'(expReadQ.pop_front()));
         end
         if (bus.dump_valid) begin
            if (firstValid < 0) firstValid = cyc;
            if (expWordQ.size() == 0) begin
               checkOutput("unexpected_valid", {31'b0, bus.dump_valid}, 32'd0);
            end else begin
               frontWord = expWordQ[0];
               checkOutput("dump_addr", 32'(bus.dump_addr), 32'(frontWord.addr));
               checkOutput("dump_word", bus.dump_word, frontWord.word);
               if (bus.dump_ready) begin
                  void'(expWordQ.pop_front());
                  sumModel = sumModel + frontWord.word;
               end
            end
         end
      end
   end

   // Caller sits just after a rising edge; start is sampled at the next edge (edge 0)
   task automatic applyStimulus(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
      int a;
      int wa;
      exp_t e;
      a = (int'(b) / 4) * 4;
      expWordQ.delete();
      expReadQ.delete();
      for (int k = 0; k < int'(n); k++) begin
         wa = (a + 4 * k) % (1 << ADDR_W);
         e.addr = ADDR_W'(wa);
         e.word = {ram[wa+3], ram[wa+2], ram[wa+1], ram[wa]};
         expWordQ.push_back(e);
         for (int j = 0; j < 4; j++) expReadQ.push_back(ADDR_W'(wa + j));
      end
      sumModel   = 32'd0;
      firstValid = -1;
      start      = 1'b1;
      base_addr  = b;
      word_count = n;
      @(posedge clk);
      #1;
      start      = 1'b0;
      base_addr  = ADDR_W'($urandom);
      word_count = CNT_W'($urandom);
      cyc        = 1;
   endtask

   task automatic waitDone(input int limit, input int glitchCycle, input int resetCycle,
                           output int doneCycle);
      doneCycle = -1;
      for (int i = 0; i < limit; i++) begin
         case (readyMode)
            0:       bus.dump_ready = 1'b1;
            1:       bus.dump_ready = cyc[0];
            default: bus.dump_ready = 1'($urandom_range(0, 1));
         endcase
         start = (cyc == glitchCycle);
         if (cyc == glitchCycle) begin
            base_addr  = ADDR_W'($urandom);
            word_count = CNT_W'(5);
         end
         reset = (cyc == resetCycle);
         @(negedge clk);
         if (done && doneCycle < 0) doneCycle = cyc;
         @(posedge clk);
         #1;
         if (cyc == resetCycle) begin
            reset = 1'b0;
            expWordQ.delete();
            expReadQ.delete();
            checkOutput("busy_after_reset", {31'b0, busy}, 32'd0);
            checkOutput("valid_after_reset", {31'b0, bus.dump_valid}, 32'd0);
            checkOutput("mem_en_after_reset", {31'b0, bus.mem_en}, 32'd0);
            cyc++;
            return;
         end
         cyc++;
         if (doneCycle >= 0) break;
      end
      start = 1'b0;
      checkOutput("done_seen", {31'b0, doneCycle >= 0}, 32'd1);
      checkOutput("done_one_cycle", {31'b0, done}, 32'd0);
      checkOutput("busy_after_done", {31'b0, busy}, 32'd0);
      checkOutput("words_left", 32'(expWordQ.size()), 32'd0);
      checkOutput("reads_left", 32'(expReadQ.size()), 32'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
      checkOutput("checksum", checksum, sumModel);
`endif
   endtask

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int dc;
      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'($urandom);
      reset          = 1'b1;
      start          = 1'b0;
      base_addr      = '0;
      word_count     = '0;
      bus.dump_ready = 1'b0;
      readyMode      = 0;
      cyc            = 0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_done", {31'b0, done}, 32'd0);
      checkOutput("rst_valid", {31'b0, bus.dump_valid}, 32'd0);
      checkOutput("rst_word", bus.dump_word, 32'd0);
      checkOutput("rst_addr", 32'(bus.dump_addr), 32'd0);
      checkOutput("rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
      checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
      checkOutput("rst_checksum", checksum, 32'd0);
`endif
      reset     = 1'b0;
      monitorOn = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] single word");
      ram[180] = 8'h11; ram[181] = 8'h22; ram[182] = 8'h33; ram[183] = 8'h44;
      readyMode = 0;
      applyStimulus(9'd180, 8'd1);
      waitDone(40, -1, -1, dc);
      checkOutput("single_done_cycle", 32'(dc), 32'd6);
      checkOutput("single_first_valid", 32'(firstValid), 32'd5);
      checkOutput("single_word_held", bus.dump_word, 32'h44332211);

      $display("[TB] multi-word with toggling ready");
      readyMode = 1;
      applyStimulus(9'd180, 8'd11);
      waitDone(200, -1, -1, dc);

      $display("[TB] alignment and wrap");
      readyMode = 0;
      applyStimulus(9'h1FF, 8'd2);
      waitDone(60, -1, -1, dc);
      checkOutput("wrap_done_cycle", 32'(dc), 32'd11);

      $display("[TB] zero count");
      applyStimulus(ADDR_W'($urandom), 8'd0);
      waitDone(20, -1, -1, dc);
      checkOutput("zero_done_cycle", 32'(dc), 32'd1);

      $display("[TB] start ignored while reading");
      applyStimulus(9'd100, 8'd2);
      waitDone(60, 2, -1, dc);
      checkOutput("ignored_start_done_cycle", 32'(dc), 32'd11);

      $display("[TB] reset mid-dump");
      applyStimulus(ADDR_W'($urandom), 8'd4);
      waitDone(60, -1, 7, dc);
      checkOutput("no_done_before_reset", {31'b0, dc < 0}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("no_done_after_reset", {31'b0, done}, 32'd0);
         checkOutput("idle_after_reset", {31'b0, bus.mem_en | bus.dump_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      applyStimulus(ADDR_W'($urandom), 8'd3);
      waitDone(100, -1, -1, dc);
      checkOutput("fresh_done_cycle", 32'(dc), 32'd16);

      $display("[TB] checksum words");
      ram[40] = 8'hFF; ram[41] = 8'hFF; ram[42] = 8'hFF; ram[43] = 8'hFF;
      ram[44] = 8'h02; ram[45] = 8'h00; ram[46] = 8'h00; ram[47] = 8'h00;
      applyStimulus(9'd40, 8'd2);
      waitDone(60, -1, -1, dc);
`ifdef MEM_DUMP_CHECKSUM_EN
      checkOutput("checksum_wrap", checksum, 32'h00000001);
`endif

      $display("[TB] random dumps");
      readyMode = 2;
      for (int t = 0; t < 8; t++) begin
         applyStimulus(ADDR_W'($urandom), CNT_W'($urandom_range(1, 20)));
         waitDone(500, -1, -1, dc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
